mips_alu_exec: RTL and testbench
================================

Name: mips_alu_exec

Overview:
- Registered MIPS execute-stage ALU that merges the ALU control decoder with a 32-bit ALU.
- Decodes a 2-bit ALUOp and a 6-bit funct field into a 4-bit ALU control code, then computes result, zero, overflow and carry.
- Sits between register-file/immediate operand selection and memory/writeback, for example for lw/sw address generation (ALUOp=00, add) and R-type arithmetic.

Parameters:
- WIDTH, 32, operand and result width in bits; the block is verified at 32 only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode are valid this cycle.
- alu_op  in  2  ALUOp from the main control unit.
- funct  in  6  instruction funct field, imm[5:0] for I-type.
- a  in  32  operand A (rs data).
- b  in  32  operand B (rt data or sign-extended immediate).
- out_valid  out  1  result registers hold a new result.
- alu_ctrl  out  4  registered decoded control code.
- result  out  32  registered ALU result.
- zero  out  1  registered flag: result == 0.
- overflow  out  1  registered signed-overflow flag.
- carry_out  out  1  registered adder carry out of bit 31.
- illegal  out  1  registered flag: unsupported funct for alu_op=10.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs go to 0 immediately, including alu_ctrl=0000 and zero=0. The outputs stay 0 until the first valid capture after rst_n rises.
- Latency is 1 cycle:
  - On a posedge with in_valid=1, all outputs update from the current inputs and out_valid is set to 1.
  - On a posedge with in_valid=0, out_valid is set to 0 and every other output holds its value.
- There is no backpressure; a new operation is accepted every cycle.
- Control decode (combinational, internal):
  - alu_op=00: add (0010).
  - alu_op=01: sub (0110).
  - alu_op=11: add (0010).
  - alu_op=10, decode from funct:
    - 100000 add: 0010
    - 100010 sub: 0110
    - 100100 and: 0000
    - 100101 or: 0001
    - 101010 slt: 0111
    - 100111 nor: 1100
    - any other funct: code 1111 and illegal=1.
  - illegal is 0 for every alu_op other than 10.
- ALU operations:
  - 0000: a & b.
  - 0001: a | b.
  - 1100: ~(a | b).
  - 0010: a + b, modulo 2^32.
  - 0110: a - b, computed as a + ~b + 1.
  - 0111: result = {31'b0, signed(a) < signed(b)}; correct even when a-b overflows.
  - 1111: result = 0.
- Flags:
  - overflow: set only for add/sub when the operand signs and result sign indicate two's-complement overflow; 0 for all other codes, including slt.
  - carry_out: set only for add/sub; it is bit 32 of the internal 33-bit sum. For sub, carry_out=1 means a >= b unsigned. It is 0 for all other codes.
  - zero: set whenever the registered result is all zeros, whatever the operation.
- Simultaneous events: reset asserted during a capture edge wins, and the outputs clear.

Optional Feature:
- Macro: MIPS_ALU_XOR_EN.
- When defined: funct 100110 with alu_op=10 decodes to 0011, result = a ^ b, overflow=0, carry_out=0, illegal=0.
- When undefined: funct 100110 is illegal (code 1111, result 0, illegal=1).

Test Plan:
- Reset: rst_n=0 mid-operation -> all outputs 0 immediately; release rst_n, apply in_valid=1, alu_op=00, a=5, b=32'hFFFFFFFF -> next cycle result=4, carry_out=1, overflow=0, alu_ctrl=0010, out_valid=1.
- Address generation (lw/sw): alu_op=00, a=3, b=7 -> result=10, zero=0; then alu_op=01, a=9, b=9 -> result=0, zero=1, carry_out=1.
- Overflow: alu_op=10, funct=100000, a=32'h7FFFFFFF, b=1 -> result=32'h80000000, overflow=1. Then funct=100010, a=32'h80000000, b=1 -> result=32'h7FFFFFFF, overflow=1.
- Logic and slt: a=32'hF0F0F0F0, b=32'h0FF00FF0 gives:
  - and -> 32'h00F000F0
  - or -> 32'hFFF0FFF0
  - nor -> 32'h000F000F
  - slt with a=32'h80000000, b=1 -> result=1
  - slt with a=1, b=32'hFFFFFFFF -> result=0
- Illegal and XOR: alu_op=10, funct=100110, a=32'hFF00FF00, b=32'h0F0F0F0F -> result=32'hF00FF00F, alu_ctrl=0011 with MIPS_ALU_XOR_EN defined; illegal=1 and result=0 without it.
- Hold: in_valid=0 for 3 cycles -> out_valid=0, and result, flags and alu_ctrl unchanged from the last valid capture.

Source files
------------

// File: rtl/mips_alu_exec_if.sv
// Execute-stage ALU bus: operands/opcode in, registered result and flags out.
interface mips_alu_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             illegal;

  modport master (
    output in_valid, alu_op, funct, a, b,
    input  out_valid, alu_ctrl, result, zero, overflow, carry_out, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b,
    output out_valid, alu_ctrl, result, zero, overflow, carry_out, illegal
  );
endinterface

// File: rtl/mips_alu_exec.sv
// Registered MIPS execute stage: ALU control decode plus 32-bit ALU, 1-cycle latency.
// Optional macro MIPS_ALU_XOR_EN enables funct 100110 as XOR (code 0011).
module mips_alu_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mips_alu_exec_if.slave  bus
);

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_XOR = 4'b0011,
    CTRL_SUB = 4'b0110,
    CTRL_SLT = 4'b0111,
    CTRL_NOR = 4'b1100,
    CTRL_ILL = 4'b1111
  } ctrl_e;

  ctrl_e            ctrl;
  logic             ill;
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             lt;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             cy;

  always_comb begin
    ctrl = CTRL_ADD;
    ill  = 1'b0;
    case (bus.alu_op)
      2'b01: ctrl = CTRL_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100000: ctrl = CTRL_ADD;
          6'b100010: ctrl = CTRL_SUB;
          6'b100100: ctrl = CTRL_AND;
          6'b100101: ctrl = CTRL_OR;
          6'b101010: ctrl = CTRL_SLT;
          6'b100111: ctrl = CTRL_NOR;
`ifdef MIPS_ALU_XOR_EN
          6'b100110: ctrl = CTRL_XOR;
`endif
          default: begin
            ctrl = CTRL_ILL;
            ill  = 1'b1;
          end
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
  end

  // Subtraction shares the adder: a + ~b + 1, so carry_out=1 means a >= b unsigned.
  assign is_sub = (ctrl == CTRL_SUB);
  assign b_op   = is_sub ? ~bus.b : bus.b;
  assign sum    = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  // Direct signed compare rather than the adder sign, so slt is right on overflow.
  assign lt     = $signed(bus.a) < $signed(bus.b);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    cy  = 1'b0;
    case (ctrl)
      CTRL_AND: res = bus.a & bus.b;
      CTRL_OR:  res = bus.a | bus.b;
      CTRL_NOR: res = ~(bus.a | bus.b);
      CTRL_ADD, CTRL_SUB: begin
        res = sum[WIDTH-1:0];
        ovf = (bus.a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        cy  = sum[WIDTH];
      end
      CTRL_SLT: res = {{(WIDTH-1){1'b0}}, lt};
`ifdef MIPS_ALU_XOR_EN
      CTRL_XOR: res = bus.a ^ bus.b;
`endif
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.alu_ctrl  <= '0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.illegal   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.alu_ctrl  <= ctrl;
        bus.result    <= res;
        bus.zero      <= (res == '0);
        bus.overflow  <= ovf;
        bus.carry_out <= cy;
        bus.illegal   <= ill;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_exec.sv
// Scoreboard bench for mips_alu_exec: directed plan vectors plus randomized ops vs. an arithmetic model.
module tb_mips_alu_exec;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        carry;
    logic        ill;
  } exp_t;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t held = '0;

  mips_alu_exec_if #(.WIDTH(32)) bus ();

  mips_alu_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [1:0] op, logic [5:0] fn, logic [31:0] x, logic [31:0] y);
    exp_t   e;
    longint sx, sy, s;
    string  kind;
    e  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == 2'b01) kind = "sub";
    else if (op != 2'b10) kind = "add";
    else begin
      case (fn)
        6'h20: kind = "add";
        6'h22: kind = "sub";
        6'h24: kind = "and";
        6'h25: kind = "or";
        6'h2A: kind = "slt";
        6'h27: kind = "nor";
`ifdef MIPS_ALU_XOR_EN
        6'h26: kind = "xor";
`endif
        default: kind = "ill";
      endcase
    end
    if (kind == "add") begin
      e.ctrl = 4'b0010; e.result = x + y; s = sx + sy;
      e.carry = ({32'b0, x} + {32'b0, y}) > 64'h0000_0000_FFFF_FFFF;
      e.ovf = (s > MAXP) || (s < MINN);
    end else if (kind == "sub") begin
      e.ctrl = 4'b0110; e.result = x - y; s = sx - sy;
      e.carry = (x >= y);
      e.ovf = (s > MAXP) || (s < MINN);
    end else if (kind == "and") begin
      e.ctrl = 4'b0000; e.result = x & y;
    end else if (kind == "or") begin
      e.ctrl = 4'b0001; e.result = x | y;
    end else if (kind == "nor") begin
      e.ctrl = 4'b1100; e.result = ~(x | y);
    end else if (kind == "slt") begin
      e.ctrl = 4'b0111; e.result = (sx < sy) ? 32'd1 : 32'd0;
    end else if (kind == "xor") begin
      e.ctrl = 4'b0011; e.result = x ^ y;
    end else begin
      e.ctrl = 4'b1111; e.result = 32'd0; e.ill = 1'b1;
    end
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_fields(string tag, exp_t e);
    check({tag, "_ctrl"},     {28'b0, bus.alu_ctrl},  {28'b0, e.ctrl});
    check({tag, "_result"},   bus.result,             e.result);
    check({tag, "_zero"},     {31'b0, bus.zero},      {31'b0, e.zero});
    check({tag, "_overflow"}, {31'b0, bus.overflow},  {31'b0, e.ovf});
    check({tag, "_carry"},    {31'b0, bus.carry_out}, {31'b0, e.carry});
    check({tag, "_illegal"},  {31'b0, bus.illegal},   {31'b0, e.ill});
  endtask

  // Monitor: pop on every presented result; on idle cycles outputs must hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_valid: got out_valid=1 expected no pending op at %0t", $time);
          end else begin
            held = q.pop_front();
            check_fields("op", held);
          end
        end else begin
          check_fields("hold", held);
        end
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [5:0] fn, logic [31:0] x, logic [31:0] y);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.a        = x;
    bus.b        = y;
    q.push_back(model(op, fn, x, y));
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [8];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_FFFF};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fset [7];
    logic [31:0] r;
    fset = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h26};
    bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'h0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check_fields("reset", '0);
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;

    issue(2'b00, 6'h00, 32'd3, 32'd7);
    issue(2'b10, 6'h22, 32'd9, 32'd2);
    // Reset mid-operation: inputs valid, rst_n drops before the capture edge.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = 2'b01; bus.a = 32'd1; bus.b = 32'd2;
    #2 rst_n = 1'b0;
    #1;
    check_fields("async_reset", '0);
    check("async_reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    q.delete();
    held = '0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    issue(2'b00, 6'h00, 32'd5, 32'hFFFF_FFFF);
    issue(2'b00, 6'h00, 32'd3, 32'd7);
    issue(2'b01, 6'h00, 32'd9, 32'd9);
    issue(2'b10, 6'h20, 32'h7FFF_FFFF, 32'd1);
    issue(2'b10, 6'h22, 32'h8000_0000, 32'd1);
    issue(2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(2'b10, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(2'b10, 6'h27, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(2'b10, 6'h2A, 32'h8000_0000, 32'd1);
    issue(2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF);
    issue(2'b10, 6'h26, 32'hFF00_FF00, 32'h0F0F_0F0F);
    issue(2'b11, 6'h3F, 32'h1234_5678, 32'h1111_1111);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) idle($urandom_range(1, 3));
      else issue(2'($urandom_range(0, 3)),
                 (r < 7) ? fset[$urandom_range(0, 6)] : 6'($urandom_range(0, 63)),
                 pick_operand(), pick_operand());
    end
    idle(2);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
